// File: rtl/param_stack_pkg.sv
// Shared constants for param_stack: default geometry and the {push,pop} op encoding.
package stack_pkg;

  localparam int STACK_WIDTH = 12;
  localparam int STACK_DEPTH = 8;

  // Encoded as {push, pop}.
  localparam logic [1:0] OP_IDLE = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_PUSH = 2'b10;
  localparam logic [1:0] OP_REPL = 2'b11;

endpackage

// File: rtl/param_stack.sv
// Parametrised LIFO return stack with registered pop, replace path, sticky error flags.
// Define PARAM_STACK_WRAP_EN for circular mode (push on full overwrites the oldest entry).
module param_stack
  import stack_pkg::*;
#(
  parameter int  WIDTH = STACK_WIDTH,
  parameter int  DEPTH = STACK_DEPTH,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  input  logic             clear_err,
  output logic [WIDTH-1:0] pop_data,
  output logic             pop_valid,
  output logic [WIDTH-1:0] top_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  output logic             underflow
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] pop_data_q, pop_data_d;
  logic             pop_valid_q, pop_valid_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             we;
  logic [AW-1:0]    waddr, top_idx, push_idx;

`ifdef PARAM_STACK_WRAP_EN
  localparam int PW = CW + 1;
  logic [AW-1:0] bot_q, bot_d;

  // Logical offset from the bottom pointer to a physical slot; explicit
  // compare keeps non-power-of-2 depths correct.
  function automatic logic [AW-1:0] phys(input logic [CW-1:0] off);
    logic [PW-1:0] sum;
    sum = PW'(bot_q) + PW'(off);
    if (sum >= PW'(DEPTH)) sum = sum - PW'(DEPTH);
    return AW'(sum);
  endfunction
`else
  function automatic logic [AW-1:0] phys(input logic [CW-1:0] off);
    return AW'(off);
  endfunction
`endif

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // When full, offset DEPTH wraps back to the bottom slot (only used in circular mode).
  assign push_idx = phys(full  ? '0 : count_q);
  assign top_idx  = phys(empty ? '0 : count_q - CW'(1));

  always_comb begin
    count_d     = count_q;
    pop_data_d  = pop_data_q;
    pop_valid_d = 1'b0;
    ovf_d       = ovf_q & ~clear_err;
    unf_d       = unf_q & ~clear_err;
    we          = 1'b0;
    waddr       = push_idx;
`ifdef PARAM_STACK_WRAP_EN
    bot_d       = bot_q;
`endif
    case ({push, pop})
      OP_PUSH: begin
        if (!full) begin
          we      = 1'b1;
          count_d = count_q + CW'(1);
        end else begin
          ovf_d = 1'b1;
`ifdef PARAM_STACK_WRAP_EN
          we    = 1'b1;
          bot_d = (bot_q == AW'(DEPTH - 1)) ? '0 : bot_q + AW'(1);
`endif
        end
      end
      OP_POP: begin
        if (!empty) begin
          pop_data_d  = mem_q[top_idx];
          pop_valid_d = 1'b1;
          count_d     = count_q - CW'(1);
        end else begin
          unf_d = 1'b1;
        end
      end
      OP_REPL: begin
        pop_valid_d = 1'b1;
        if (!empty) begin
          pop_data_d = mem_q[top_idx];
          we         = 1'b1;
          waddr      = top_idx;
        end else begin
          pop_data_d = push_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q     <= '0;
      pop_data_q  <= '0;
      pop_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
`ifdef PARAM_STACK_WRAP_EN
      bot_q       <= '0;
`endif
    end else begin
      count_q     <= count_d;
      pop_data_q  <= pop_data_d;
      pop_valid_q <= pop_valid_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
`ifdef PARAM_STACK_WRAP_EN
      bot_q       <= bot_d;
`endif
    end
  end

  // Storage is not reset; the replace path reads and writes the same slot here.
  always_ff @(posedge clk) begin
    if (we && !rst) mem_q[waddr] <= push_data;
  end

  assign pop_data  = pop_data_q;
  assign pop_valid = pop_valid_q;
  assign top_data  = empty ? '0 : mem_q[top_idx];
  assign count     = count_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_param_stack.sv
// Directed self-checking bench for param_stack (WIDTH=12, DEPTH=8); follows PARAM_STACK_WRAP_EN.
module tb_param_stack;

  logic        clk = 1'b0;
  logic        rst, push, pop, clear_err;
  logic [11:0] push_data;
  logic [11:0] pop_data, top_data;
  logic        pop_valid, full, empty, overflow, underflow;
  logic [3:0]  count;

  int err_cnt = 0;
  int chk_cnt = 0;

  param_stack #(.WIDTH(12), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .push_data(push_data),
    .clear_err(clear_err), .pop_data(pop_data), .pop_valid(pop_valid),
    .top_data(top_data), .count(count), .full(full), .empty(empty),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, then settle 1 time unit past the edge for sampling.
  task automatic step(input logic r, input logic ps, input logic pp,
                      input logic [11:0] d, input logic ce);
    rst = r; push = ps; pop = pp; push_data = d; clear_err = ce;
    @(posedge clk);
    #1;
    rst = 1'b0; push = 1'b0; pop = 1'b0; push_data = '0; clear_err = 1'b0;
  endtask

  logic [11:0] exp_pop [8];
  logic [11:0] last_pop;

  initial begin
    rst = 1'b0; push = 1'b0; pop = 1'b0; push_data = '0; clear_err = 1'b0;
    @(negedge clk);

    // Reset state
    step(1, 0, 0, 12'h0, 0);
    step(1, 0, 0, 12'h0, 0);
    chk("rst_count", count, 0);
    chk("rst_popv", pop_valid, 0);
    chk("rst_popd", pop_data, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_unf", underflow, 0);
    chk("rst_empty", empty, 1);
    chk("rst_top", top_data, 0);

    // Fill 0x001..0x008
    for (int i = 1; i <= 8; i++) begin
      step(0, 1, 0, 12'(i), 0);
      chk("fill_count", count, i);
      chk("fill_top", top_data, i);
    end
    chk("full_flag", full, 1);
    chk("full_ovf", overflow, 0);

    // Push on full
    step(0, 1, 0, 12'h0FF, 0);
    chk("ovf_set", overflow, 1);
    chk("ovf_count", count, 8);
`ifdef PARAM_STACK_WRAP_EN
    chk("ovf_top", top_data, 12'h0FF);
    exp_pop[0] = 12'h0FF;
    for (int i = 1; i < 8; i++) exp_pop[i] = 12'(9 - i);
`else
    chk("ovf_top", top_data, 12'h008);
    for (int i = 0; i < 8; i++) exp_pop[i] = 12'(8 - i);
`endif

    // Drain
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 1, 12'h0, 0);
      chk("drain_data", pop_data, exp_pop[i]);
      chk("drain_valid", pop_valid, 1);
      chk("drain_count", count, 7 - i);
    end
    chk("drain_empty", empty, 1);
    chk("drain_top", top_data, 0);
    last_pop = exp_pop[7];

    // Pop on empty
    step(0, 0, 1, 12'h0, 0);
    chk("unf_set", underflow, 1);
    chk("unf_valid", pop_valid, 0);
    chk("unf_data", pop_data, last_pop);
    chk("unf_count", count, 0);

    // clear_err with both flags set
    step(0, 0, 0, 12'h0, 1);
    chk("clr_ovf", overflow, 0);
    chk("clr_unf", underflow, 0);

    // Replace path on non-empty stack
    step(0, 1, 0, 12'h0A1, 0);
    step(0, 1, 0, 12'h0A2, 0);
    step(0, 1, 1, 12'h0B3, 0);
    chk("repl_data", pop_data, 12'h0A2);
    chk("repl_valid", pop_valid, 1);
    chk("repl_count", count, 2);
    chk("repl_top", top_data, 12'h0B3);
    chk("repl_ovf", overflow, 0);
    step(0, 0, 0, 12'h0, 0);
    chk("idle_valid", pop_valid, 0);
    step(0, 0, 1, 12'h0, 0);
    chk("repl_pop1", pop_data, 12'h0B3);
    step(0, 0, 1, 12'h0, 0);
    chk("repl_pop2", pop_data, 12'h0A1);
    chk("repl_empty", empty, 1);

    // Bypass on empty
    step(0, 1, 1, 12'h055, 0);
    chk("byp_data", pop_data, 12'h055);
    chk("byp_valid", pop_valid, 1);
    chk("byp_count", count, 0);
    chk("byp_unf", underflow, 0);

    // clear_err coincident with push on full: set wins
    for (int i = 1; i <= 8; i++) step(0, 1, 0, 12'(8'h10 + i), 0);
    chk("refill_full", full, 1);
    step(0, 1, 0, 12'h0EE, 1);
    chk("clrset_ovf", overflow, 1);
    chk("clrset_count", count, 8);
    step(0, 0, 0, 12'h0, 1);
    chk("clr2_ovf", overflow, 0);

    // Reset mid-sequence with push asserted
    step(1, 0, 0, 12'h0, 0);
    step(0, 0, 1, 12'h0, 0);
    chk("pre_unf", underflow, 1);
    for (int i = 1; i <= 5; i++) step(0, 1, 0, 12'(8'h20 + i), 0);
    chk("pre_count", count, 5);
    step(1, 1, 0, 12'h077, 0);
    chk("mrst_count", count, 0);
    chk("mrst_valid", pop_valid, 0);
    chk("mrst_ovf", overflow, 0);
    chk("mrst_unf", underflow, 0);
    chk("mrst_empty", empty, 1);
    chk("mrst_top", top_data, 0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
